aes_pipe_ctrl: RTL and testbench
================================

AES_PIPE_CTRL -- requirements
Module: aes_pipe_ctrl

Interface
REQ-001 Parameter MAX_ROUNDS, default 14, number of cipher rounds for AES-256; the pipeline has MAX_ROUNDS+1 stages (stage 0 = initial key add).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream block present on the stage-0 data input this cycle.
REQ-005 in_ready  output  1  controller accepts the block this cycle; accept = in_valid & in_ready.
REQ-006 mode_256  input  1  requested key length: 0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds).
REQ-007 key_ready  input  1  round-key expansion complete and stable.
REQ-008 round_en  output  MAX_ROUNDS+1  per-stage enable; bit k drives stage k enable.
REQ-009 out_valid  output  1  final-stage register holds a valid ciphertext this cycle (single-cycle pulse per block).
REQ-010 active_mode  output  1  key length currently in flight in the pipeline.
REQ-011 inflight  output  4  number of blocks accepted but not yet output.
REQ-012 busy  output  1  high when state is not IDLE.

Function
REQ-013 Nr = 10 when active_mode = 0, Nr = 14 when active_mode = 1.
REQ-014 Internal valid register v[MAX_ROUNDS:0]; v[k] = stage k output register holds a valid block.
REQ-015 Each cycle: v[0] <= accept; v[k] <= v[k-1] for k = 1..MAX_ROUNDS; no stall, no backpressure.
REQ-016 round_en[0] = accept (combinational); round_en[k] = v[k-1] for 1 <= k <= Nr; round_en[k] = 0 for k > Nr.
REQ-017 out_valid = v[Nr]; latency accept-to-out_valid = Nr+1 cycles (11 for AES-128, 15 for AES-256).
REQ-018 Back-to-back acceptance allowed every cycle; throughput 1 block/cycle.
REQ-019 inflight <= inflight + accept - out_valid; both in same cycle leaves it unchanged; never exceeds Nr+1.
REQ-020 FSM states IDLE, RUN, DRAIN.
REQ-021 IDLE: in_ready = key_ready; on accept, active_mode <= mode_256 in the same edge, go RUN.
REQ-022 RUN: in_ready = key_ready & (mode_256 == active_mode).
REQ-023 RUN -> DRAIN when mode_256 != active_mode and inflight != 0; in_ready = 0 in DRAIN.
REQ-024 RUN -> IDLE when inflight = 0 (or reaches 0 this edge) and no accept this cycle.
REQ-025 DRAIN -> IDLE when inflight reaches 0; active_mode held until IDLE accepts a new block.
REQ-026 key_ready low in any state: in_ready = 0; blocks in flight continue to completion.
REQ-027 active_mode never changes while inflight != 0.
REQ-028 v bits above Nr are never set.

Reset
REQ-029 rst = 0 at a clock edge: state IDLE, v = 0, inflight = 0, active_mode = 0; thus round_en = 0, out_valid = 0, busy = 0, in_ready = 0 only if key_ready = 0.
REQ-030 Reset mid-operation discards all in-flight blocks; no out_valid is produced for them.

Verification
REQ-031 AES-128, key_ready = 1, single in_valid pulse at cycle 0 -> round_en[k] high at cycle k (k = 0..10), out_valid high at cycle 11 only, inflight 1 for cycles 1..11, busy low at cycle 12.
REQ-032 AES-256, 20 consecutive accepts -> 20 out_valid pulses on cycles 15..34, inflight saturates at 15, round_en bits all high in steady state.
REQ-033 AES-128 stream of 3 blocks, then mode_256 = 1 with in_valid held -> in_ready low, DRAIN until last out_valid, IDLE, next accept with active_mode = 1, its out_valid 15 cycles later.
REQ-034 key_ready dropped for 4 cycles during stream -> no accepts in those cycles, in-flight blocks still output, gap of 4 in out_valid pulses.
REQ-035 rst asserted with 5 blocks in flight -> next cycle inflight = 0, round_en = 0, no out_valid ever for those blocks.
REQ-036 Accept and out_valid on same cycle -> inflight unchanged.

Source files
------------

// File: rtl/aes_pipe_ctrl.sv
// AES round-pipeline controller: valid shift chain, per-stage enables,
// in-flight accounting and key-length switching via drain.
module aes_pipe_ctrl #(
    parameter int MAX_ROUNDS = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode_256,
    input  logic                  key_ready,
    output logic [MAX_ROUNDS:0]   round_en,
    output logic                  out_valid,
    output logic                  active_mode,
    output logic [3:0]            inflight,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int NR_128 = 10;

    state_t              state, state_n;
    logic [MAX_ROUNDS:0] v, v_n;
    logic                accept;
    logic [3:0]          inflight_n;
    int                  nr;

    always_comb nr = active_mode ? MAX_ROUNDS : NR_128;

    always_comb begin
        in_ready = 1'b0;
        unique case (state)
            IDLE:    in_ready = key_ready;
            RUN:     in_ready = key_ready && (mode_256 == active_mode);
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Stages beyond Nr stay dark so their valid bits can never be set.
    always_comb begin
        round_en    = '0;
        v_n         = '0;
        out_valid   = 1'b0;
        round_en[0] = accept;
        v_n[0]      = accept;
        for (int k = 1; k <= MAX_ROUNDS; k++) begin
            if (k <= nr) begin
                round_en[k] = v[k-1];
                v_n[k]      = v[k-1];
            end
        end
        for (int k = 0; k <= MAX_ROUNDS; k++) begin
            if (k == nr) out_valid = v[k];
        end
    end

    assign inflight_n = inflight + {3'b000, accept} - {3'b000, out_valid};

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) state_n = RUN;
            end
            RUN: begin
                if (inflight_n == 4'd0 && !accept)
                    state_n = IDLE;
                else if (mode_256 != active_mode)
                    state_n = DRAIN;
            end
            DRAIN: begin
                if (inflight_n == 4'd0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            v           <= '0;
            inflight    <= 4'd0;
            active_mode <= 1'b0;
        end else begin
            state    <= state_n;
            v        <= v_n;
            inflight <= inflight_n;
            // Key length only latches on an idle (empty) pipeline.
            if (state == IDLE && accept) active_mode <= mode_256;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// Directed bench for aes_pipe_ctrl: latency, streaming, mode drain,
// key_ready gaps, overlap accounting and mid-flight reset.
module tb_aes_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        mode_256;
    logic        key_ready;
    logic [14:0] round_en;
    logic        out_valid;
    logic        active_mode;
    logic [3:0]  inflight;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    aes_pipe_ctrl #(.MAX_ROUNDS(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode_256    (mode_256),
        .key_ready   (key_ready),
        .round_en    (round_en),
        .out_valid   (out_valid),
        .active_mode (active_mode),
        .inflight    (inflight),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Directed stream from an empty pipeline with a fixed key length.
    // vmask: cycles with in_valid; kmask: cycles with key_ready low.
    task automatic run_seq(input string tag, input logic mode,
                           input logic [63:0] vmask,
                           input logic [63:0] kmask,
                           input int ncyc, input int lat);
        logic [63:0] acc;
        int          n_acc;
        int          n_out;
        logic [31:0] exp_en;
        logic        exp_out;
        acc   = vmask & ~kmask;
        n_acc = 0;
        n_out = 0;
        for (int c = 0; c < ncyc; c++) begin
            in_valid  = vmask[c];
            key_ready = !kmask[c];
            mode_256  = mode;
            #1;
            exp_out = (c >= lat) && acc[c-lat];
            exp_en  = 0;
            for (int k = 0; k < lat; k++)
                if (c - k >= 0 && acc[c-k]) exp_en[k] = 1'b1;
            chk({tag, " in_ready"}, 32'(in_ready), 32'(!kmask[c]));
            chk({tag, " round_en"}, 32'(round_en), exp_en);
            chk({tag, " out_valid"}, 32'(out_valid), 32'(exp_out));
            chk({tag, " inflight"}, 32'(inflight), 32'(n_acc - n_out));
            chk({tag, " busy"}, 32'(busy), 32'(n_acc != n_out));
            if (n_acc > 0)
                chk({tag, " active_mode"}, 32'(active_mode), 32'(mode));
            if (acc[c]) n_acc++;
            if (exp_out) n_out++;
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] m20, m10, k4, m3, m5;
        rst       = 1'b0;
        in_valid  = 1'b0;
        mode_256  = 1'b0;
        key_ready = 1'b1;
        next_cycle();
        next_cycle();
        chk("rst round_en", 32'(round_en), 32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst inflight", 32'(inflight), 32'h0);
        chk("rst active_mode", 32'(active_mode), 32'h0);
        chk("rst in_ready", 32'(in_ready), 32'h1);
        key_ready = 1'b0;
        #1;
        chk("rst in_ready kr0", 32'(in_ready), 32'h0);
        key_ready = 1'b1;
        rst = 1'b1;
        next_cycle();

        // single AES-128 block: enables walk stages 0..10, out at 11
        run_seq("single128", 1'b0, 64'h1, 64'h0, 14, 11);

        // 20 back-to-back AES-256 blocks
        m20 = 64'hF_FFFF;
        run_seq("stream256", 1'b1, m20, 64'h0, 38, 15);

        // key_ready low for 4 cycles inside an AES-128 stream
        m10 = 64'h3FF;
        k4  = 64'h78;
        run_seq("keygap", 1'b0, m10, k4, 24, 11);

        // accept and out_valid in the same cycle
        m3 = 64'h1801;
        run_seq("overlap", 1'b0, m3, 64'h0, 26, 11);

        // AES-128 -> AES-256 switch with in_valid held
        for (int c = 0; c < 32; c++) begin
            in_valid  = (c <= 14);
            mode_256  = (c >= 3);
            key_ready = 1'b1;
            #1;
            if (c <= 14)
                chk("switch in_ready", 32'(in_ready),
                    32'(c <= 2 || c == 14));
            chk("switch out_valid", 32'(out_valid),
                32'(c == 11 || c == 12 || c == 13 || c == 29));
            if (c >= 1)
                chk("switch active_mode", 32'(active_mode),
                    32'(c >= 15));
            if (c == 5 || c == 14 || c == 20 || c == 30)
                chk("switch busy", 32'(busy), 32'(c != 14 && c != 30));
            if (c == 5)
                chk("switch inflight", 32'(inflight), 32'd3);
            next_cycle();
        end
        in_valid = 1'b0;

        // reset with 5 blocks in flight
        m5 = 64'h1F;
        for (int c = 0; c < 22; c++) begin
            in_valid = m5[c];
            mode_256 = 1'b0;
            rst      = (c != 6);
            #1;
            if (c == 6)
                chk("rstmid inflight pre", 32'(inflight), 32'd5);
            if (c == 7) begin
                chk("rstmid inflight", 32'(inflight), 32'd0);
                chk("rstmid round_en", 32'(round_en), 32'h0);
                chk("rstmid busy", 32'(busy), 32'h0);
            end
            if (c >= 7)
                chk("rstmid out_valid", 32'(out_valid), 32'h0);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
